// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I instruction descriptions (R/I/S/B/U/J) into
// 32-bit words and streams them into instruction memory at consecutive
// word addresses, one load session per start pulse.
// Optional feature: define INSTR_ENCODER_RANGE_CHECK_EN to drop requests
// whose immediate does not fit the selected format's field.
module instr_encoder #(
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  start,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            in_format,
   input  logic [6:0]            in_opcode,
   input  logic [2:0]            in_funct3,
   input  logic [6:0]            in_funct7,
   input  logic [4:0]            in_rd,
   input  logic [4:0]            in_rs1,
   input  logic [4:0]            in_rs2,
   input  logic [31:0]           in_imm,
   output logic                  imem_wren,
   input  logic                  imem_ready,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FULL = 2'd2
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_S = 3'd2;
   localparam logic [2:0] FMT_B = 3'd3;
   localparam logic [2:0] FMT_U = 3'd4;
   localparam logic [2:0] FMT_J = 3'd5;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  err_q, err_d;
   logic                  wren_q, wren_d;
   logic [31:0]           wdata_q, wdata_d;

   logic                  ready_int;
   logic                  accept;
   logic                  handshake;
   logic                  last_pending;
   logic                  is_shift;
   logic                  fmt_ok;
   logic                  range_ok;
   logic [31:0]           enc_word;

   assign is_shift     = (in_opcode == 7'b0010011) &&
                         ((in_funct3 == 3'b001) || (in_funct3 == 3'b101));
   assign handshake    = wren_q & imem_ready;
   // once the word for the last address is pending nothing more can be stored
   assign last_pending = wren_q & (ptr_q == LAST_ADDR);
   assign accept       = in_valid & ready_int;

   // Field packing for each instruction format; illegal formats flag fmt_ok=0
   always_comb begin
      enc_word = '0;
      fmt_ok   = 1'b1;
      case (in_format)
         FMT_R: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
         FMT_I: begin
            if (is_shift) begin
               enc_word = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
            end else begin
               enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            end
         end
         FMT_S: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
         FMT_B: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], in_opcode};
         FMT_U: enc_word = {in_imm[31:12], in_rd, in_opcode};
         FMT_J: enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                            in_rd, in_opcode};
         default: fmt_ok = 1'b0;
      endcase
   end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
   // Immediate must be representable in the format's field without truncation
   always_comb begin
      range_ok = 1'b1;
      case (in_format)
         FMT_I: begin
            if (is_shift) begin
               range_ok = ~|in_imm[31:5];
            end else begin
               range_ok = (&in_imm[31:11]) | (~|in_imm[31:11]);
            end
         end
         FMT_S: range_ok = (&in_imm[31:11]) | (~|in_imm[31:11]);
         FMT_B: range_ok = ((&in_imm[31:12]) | (~|in_imm[31:12])) & ~in_imm[0];
         FMT_U: range_ok = ~|in_imm[11:0];
         FMT_J: range_ok = ((&in_imm[31:20]) | (~|in_imm[31:20])) & ~in_imm[0];
         default: range_ok = 1'b1;
      endcase
   end
`else
   assign range_ok = 1'b1;
`endif

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: start (re)opens a session, last-address write ends it
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start) state_d = S_RUN;
         S_RUN: begin
            if (start) begin
               state_d = S_RUN;
            end else if (handshake && (ptr_q == LAST_ADDR)) begin
               state_d = S_FULL;
            end
         end
         S_FULL: if (start) state_d = S_RUN;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      ready_int = (state_q == S_RUN) & (~wren_q | imem_ready) & ~start & ~last_pending;
      busy      = (state_q == S_RUN);
      done      = (state_q == S_FULL);
   end

   // Datapath next values: a handshake retires the held word and a new
   // request may load the output register on the same edge at ptr+1
   always_comb begin
      ptr_d   = ptr_q;
      count_d = count_q;
      err_d   = err_q;
      wren_d  = wren_q;
      wdata_d = wdata_q;
      if (start) begin
         ptr_d   = '0;
         count_d = '0;
         err_d   = 1'b0;
         wren_d  = 1'b0;
      end else begin
         if (handshake) begin
            count_d = count_q + 1'b1;
            wren_d  = 1'b0;
            if (ptr_q != LAST_ADDR) begin
               ptr_d = ptr_q + 1'b1;
            end
         end
         if (accept) begin
            if (fmt_ok && range_ok) begin
               wren_d  = 1'b1;
               wdata_d = enc_word;
            end else begin
               err_d = 1'b1;
            end
         end
      end
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (!rstn) begin
         ptr_q   <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
         wren_q  <= 1'b0;
         wdata_q <= '0;
      end else begin
         ptr_q   <= ptr_d;
         count_q <= count_d;
         err_q   <= err_d;
         wren_q  <= wren_d;
         wdata_q <= wdata_d;
      end
   end

   assign in_ready   = ready_int;
   assign imem_wren  = wren_q;
   assign imem_addr  = ptr_q;
   assign imem_wdata = wdata_q;
   assign count      = count_q;
   assign err        = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: transaction-level model (words written so far,
// pending word, sticky error) checked every cycle, plus directed scenarios.
module tb_instr_encoder;

   localparam int AW   = 2;
   localparam int CAP  = 1 << AW;
   localparam int LAST = CAP - 1;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          start = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [2:0]    in_format = '0;
   logic [6:0]    in_opcode = '0;
   logic [2:0]    in_funct3 = '0;
   logic [6:0]    in_funct7 = '0;
   logic [4:0]    in_rd = '0;
   logic [4:0]    in_rs1 = '0;
   logic [4:0]    in_rs2 = '0;
   logic [31:0]   in_imm = '0;
   logic          imem_wren;
   logic          imem_ready = 1'b1;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic [AW:0]   count;
   logic          busy;
   logic          done;
   logic          err;

   int checks = 0;
   int failures = 0;

   instr_encoder #(.ADDR_WIDTH(AW)) dut (
      .clk(clk), .rstn(rstn), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_format(in_format), .in_opcode(in_opcode), .in_funct3(in_funct3),
      .in_funct7(in_funct7), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_imm(in_imm), .imem_wren(imem_wren), .imem_ready(imem_ready),
      .imem_addr(imem_addr), .imem_wdata(imem_wdata), .count(count),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // ---------------- reference encoder from the field rules ----------------
   function automatic logic [31:0] m_enc(input int fmt, input int op, input int f3,
                                         input int f7, input int rd, input int rs1,
                                         input int rs2, input logic [31:0] imm,
                                         output bit legal);
      logic [31:0] w;
      int          s;
      bit          fits;
      s     = int'(imm);
      w     = 32'(op) | (32'(f3) << 12);
      legal = 1'b1;
      fits  = 1'b1;
      case (fmt)
         0: w = w | (32'(rd) << 7) | (32'(rs1) << 15) | (32'(rs2) << 20) | (32'(f7) << 25);
         1: begin
            w = w | (32'(rd) << 7) | (32'(rs1) << 15);
            if (op == 'h13 && (f3 == 1 || f3 == 5)) begin
               w    = w | ((imm % 32) << 20) | (32'(f7) << 25);
               fits = (imm < 32);
            end else begin
               w    = w | ((imm % 4096) << 20);
               fits = (s >= -2048 && s <= 2047);
            end
         end
         2: begin
            w    = w | ((imm % 32) << 7) | (32'(rs1) << 15) | (32'(rs2) << 20)
                     | (((imm / 32) % 128) << 25);
            fits = (s >= -2048 && s <= 2047);
         end
         3: begin
            w    = w | (((imm / 2048) % 2) << 7) | (((imm / 2) % 16) << 8)
                     | (32'(rs1) << 15) | (32'(rs2) << 20)
                     | (((imm / 32) % 64) << 25) | (((imm / 4096) % 2) << 31);
            fits = (s >= -4096 && s <= 4095 && (s % 2) == 0);
         end
         4: begin
            w    = 32'(op) | (32'(rd) << 7) | ((imm / 4096) << 12);
            fits = ((imm % 4096) == 0);
         end
         5: begin
            w    = 32'(op) | (32'(rd) << 7) | (((imm / 4096) % 256) << 12)
                     | (((imm / 2048) % 2) << 20) | (((imm / 2) % 1024) << 21)
                     | (((imm / 1048576) % 2) << 31);
            fits = (s >= -1048576 && s <= 1048575 && (s % 2) == 0);
         end
         default: legal = 1'b0;
      endcase
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
      if (!fits) legal = 1'b0;
`else
      if (!fits) legal = legal;
`endif
      return w;
   endfunction

   // ---------------- session model ----------------
   bit          m_run = 0, m_full = 0, m_err = 0, m_pend = 0;
   int          m_count = 0;
   logic [31:0] m_data = '0;

   // Next word always lands at the number of words already written
   function automatic bit m_ready();
      return m_run && !start && (!m_pend || imem_ready) && !(m_pend && m_count == LAST);
   endfunction

   always @(posedge clk) begin
      bit          rdy, hs, legal;
      logic [31:0] w;
      if (!rstn) begin
         m_run = 0; m_full = 0; m_err = 0; m_pend = 0; m_count = 0;
      end else if (start) begin
         m_run = 1; m_full = 0; m_err = 0; m_pend = 0; m_count = 0;
      end else if (m_run) begin
         rdy = m_ready();
         hs  = m_pend && imem_ready;
         if (hs) begin
            m_pend = 0;
            m_count++;
            if (m_count == CAP) begin
               m_run  = 0;
               m_full = 1;
            end
         end
         if (in_valid && rdy) begin
            w = m_enc(int'(in_format), int'(in_opcode), int'(in_funct3), int'(in_funct7),
                      int'(in_rd), int'(in_rs1), int'(in_rs2), in_imm, legal);
            if (legal) begin
               m_pend = 1;
               m_data = w;
            end else begin
               m_err = 1;
            end
         end
      end
   end

   // Per-cycle comparison against the model
   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         chk("wren", 64'(imem_wren), 64'(m_pend));
         chk("in_ready", 64'(in_ready), 64'(m_ready()));
         chk("count", 64'(count), 64'(m_count));
         chk("busy", 64'(busy), 64'(m_run));
         chk("done", 64'(done), 64'(m_full));
         chk("err", 64'(err), 64'(m_err));
         if (m_pend) begin
            chk("addr", 64'(imem_addr), 64'(m_count % CAP));
            chk("wdata", 64'(imem_wdata), 64'(m_data));
         end
      end
   end

   // Log of completed writes for directed checks
   logic [31:0] log_addr[$];
   logic [31:0] log_data[$];
   always @(negedge clk) begin
      if (rstn && imem_wren && imem_ready && !start) begin
         log_addr.push_back(32'(imem_addr));
         log_data.push_back(imem_wdata);
      end
   end

   // ---------------- stimulus helpers (called just after a rising edge) ----
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
      log_addr.delete();
      log_data.delete();
   endtask

   task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm, input int lim,
                       output bit ok);
      bit r;
      in_format = f; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
      in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
      in_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         r = in_ready;
         step();
         if (r) begin
            ok = 1'b1;
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (!imem_wren) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      chk("drain_timeout", 64'(ok), 64'd1);
   endtask

   task automatic chk_log(input string name, input int idx, input int a, input logic [31:0] d);
      if (idx < log_addr.size()) begin
         chk({name, "_addr"}, 64'(log_addr[idx]), 64'(a));
         chk({name, "_data"}, 64'(log_data[idx]), 64'(d));
      end else begin
         chk({name, "_present"}, 64'(log_addr.size()), 64'(idx + 1));
      end
   endtask

   initial begin
      bit          ok, legal;
      int          acc;
      logic [31:0] a_addr, a_data;

      // model pins against hand-computed words
      chk("model_addi", 64'(m_enc(1, 'h13, 0, 0, 1, 0, 0, 32'd5, legal)), 64'h00500093);
      chk("model_sub", 64'(m_enc(0, 'h33, 0, 'h20, 3, 1, 2, 32'd0, legal)), 64'h402081B3);
      chk("model_beq", 64'(m_enc(3, 'h63, 0, 0, 0, 1, 2, 32'hFFFFFFFC, legal)), 64'hFE208EE3);
      chk("model_lui", 64'(m_enc(4, 'h37, 0, 0, 5, 0, 0, 32'h12345000, legal)), 64'h123452B7);
      chk("model_jal", 64'(m_enc(5, 'h6F, 0, 0, 1, 0, 0, 32'd8, legal)), 64'h008000EF);

      // reset values
      step(); step();
      @(negedge clk);
      chk("rst_wren", 64'(imem_wren), 64'd0);
      chk("rst_ready", 64'(in_ready), 64'd0);
      chk("rst_addr", 64'(imem_addr), 64'd0);
      chk("rst_wdata", 64'(imem_wdata), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_flags", 64'({busy, done, err}), 64'd0);
      step();
      rstn = 1'b1;
      step();

      // basic encodes
      pulse_start();
      send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 20, ok);
      send(3'd0, 7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0, 20, ok);
      drain();
      chk_log("addi", 0, 0, 32'h00500093);
      chk_log("sub", 1, 1, 32'h402081B3);
      chk("basic_count", 64'(count), 64'd2);
      chk("basic_err", 64'(err), 64'd0);

      // branch / upper / jump
      pulse_start();
      send(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 20, ok);
      send(3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345000, 20, ok);
      send(3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd8, 20, ok);
      drain();
      chk_log("beq", 0, 0, 32'hFE208EE3);
      chk_log("lui", 1, 1, 32'h123452B7);
      chk_log("jal", 2, 2, 32'h008000EF);

      // backpressure on the first word
      pulse_start();
      imem_ready = 1'b0;
      send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 20, ok);
      a_addr = 32'(imem_addr);
      a_data = imem_wdata;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_addr", 64'(imem_addr), 64'(a_addr));
         chk("bp_data", 64'(imem_wdata), 64'(a_data));
         chk("bp_ready", 64'(in_ready), 64'd0);
      end
      imem_ready = 1'b1;
      send(3'd0, 7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0, 20, ok);
      send(3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd8, 20, ok);
      drain();
      chk_log("bp0", 0, 0, 32'h00500093);
      chk_log("bp1", 1, 1, 32'h402081B3);
      chk_log("bp2", 2, 2, 32'h008000EF);

      // immediate outside the I field
      pulse_start();
      send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h800, 20, ok);
      drain();
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
      chk("range_err", 64'(err), 64'd1);
      chk("range_nowrite", 64'(log_addr.size()), 64'd0);
      send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 20, ok);
      drain();
      chk_log("range_next", 0, 0, 32'h00500093);
`else
      chk("range_err", 64'(err), 64'd0);
      chk_log("range_trunc", 0, 0, 32'h80000093);
`endif

      // fill to FULL
      pulse_start();
      acc = 0;
      for (int k = 0; k < 5; k++) begin
         send(3'd1, 7'h13, 3'd0, 7'h00, 5'(k + 1), 5'd0, 5'd0, 32'(k), 6, ok);
         acc += int'(ok);
      end
      drain();
      chk("full_accepted", 64'(acc), 64'(CAP));
      chk("full_done", 64'(done), 64'd1);
      chk("full_ready", 64'(in_ready), 64'd0);
      chk("full_count", 64'(count), 64'(CAP));
      for (int k = 0; k < CAP; k++) chk_log("full_w", k, k, 32'h00000013 | (32'(k) << 20) | (32'(k + 1) << 7));
      pulse_start();
      chk("restart_count", 64'(count), 64'd0);
      send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 20, ok);
      drain();
      chk_log("restart", 0, 0, 32'h00500093);

      // reset while a write is stalled
      imem_ready = 1'b0;
      send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd7, 20, ok);
      rstn = 1'b0;
      step();
      chk("rst2_wren", 64'(imem_wren), 64'd0);
      chk("rst2_addr", 64'(imem_addr), 64'd0);
      chk("rst2_wdata", 64'(imem_wdata), 64'd0);
      chk("rst2_count", 64'(count), 64'd0);
      chk("rst2_flags", 64'({in_ready, busy, done, err}), 64'd0);
      rstn = 1'b1;
      imem_ready = 1'b1;
      step();
      pulse_start();
      send(3'd7, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd1, 20, ok);
      step();
      chk("illegal_err", 64'(err), 64'd1);
      chk("illegal_nowrite", 64'({imem_wren, 32'(log_addr.size())}), 64'd0);

      // randomized traffic, checked by the per-cycle model compare
      for (int c = 0; c < 1500; c++) begin
         start      = ($urandom_range(0, 39) == 0);
         imem_ready = ($urandom_range(0, 9) < 7);
         in_valid   = ($urandom_range(0, 9) < 6);
         in_format  = 3'($urandom_range(0, 7));
         in_opcode  = ($urandom_range(0, 1) == 0) ? 7'h13 : 7'($urandom);
         in_funct3  = 3'($urandom);
         in_funct7  = 7'($urandom);
         in_rd      = 5'($urandom);
         in_rs1     = 5'($urandom);
         in_rs2     = 5'($urandom);
         case ($urandom_range(0, 3))
            0: in_imm = $urandom;
            1: in_imm = 32'($signed(12'($urandom)));
            2: in_imm = 32'($urandom_range(0, 31));
            default: in_imm = $urandom & 32'hFFFFF000;
         endcase
         step();
      end
      start = 1'b0;
      in_valid = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
